li_credit_arbiter: RTL and testbench

Shares one latency-insensitive interconnect link between N_REQ FIR-stage senders. Requesters are selected round-robin, one word per cycle, and the winner's word is forwarded on a registered output. Admission is gated by a credit counter that tracks free slots in the downstream receiver. The block sits on the sender side of an interconnect_gen pipeline of type "credit"; its output drives that pipeline's i_data/i_valid, and its i_li_feedback takes the pipeline's credit-return feedback.

---
 rtl/li_credit_arbiter.sv | 133 +++++++++++++
 tb/tb_li_credit_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/li_credit_arbiter.sv
// Round-robin arbiter sharing one credit-flow-controlled link between N_REQ senders.
// Winner's word is registered onto the link; a credit counter tracks free receiver slots.
module li_credit_arbiter #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned CREDITS    = 8,
   parameter int unsigned SRC_W      = $clog2(N_REQ)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [N_REQ*DATA_WIDTH-1:0]   i_data,
   input  logic [N_REQ-1:0]              i_valid,
   output logic [N_REQ-1:0]              o_li_feedback,
   output logic signed [DATA_WIDTH-1:0]  o_data,
   output logic                          o_valid,
   output logic [SRC_W-1:0]              o_src,
   input  logic                          i_li_feedback,
   output logic                          o_credit_err
);

   localparam int unsigned CNT_W = $clog2(CREDITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CREDITS);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [SRC_W-1:0] SRC_LAST  = SRC_W'(N_REQ - 1);
   localparam logic [SRC_W-1:0] SRC_ONE   = SRC_W'(1);
   localparam logic [SRC_W:0]   N_REQ_EXT = (SRC_W + 1)'(N_REQ);

   // Handshake: requester k transfers its word in any cycle where i_valid[k] and
   // o_li_feedback[k] are both high; it must hold word and valid until then.
   // The link side has no ready: o_valid pushes, and flow control is purely by credits.

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SRC_W-1:0]      ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic [SRC_W-1:0]      src_q, src_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] words [N_REQ];
   logic                  can_send;
   logic                  grant_found;
   logic [SRC_W-1:0]      grant_idx;
   logic [SRC_W:0]        cand;
   logic                  send;
   logic                  ret;

   for (genvar k = 0; k < int'(N_REQ); k++) begin : g_words
      assign words[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
   end

   assign can_send = (cnt_q != '0) && !reset;

   // First valid requester at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         cand = {1'b0, ptr_q} + (SRC_W + 1)'(i);
         if (cand >= N_REQ_EXT) begin
            cand = cand - N_REQ_EXT;
         end
         if (!grant_found && i_valid[cand[SRC_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[SRC_W-1:0];
         end
      end
   end

   always_comb begin
      o_li_feedback = '0;
      if (can_send && grant_found) begin
         o_li_feedback[grant_idx] = 1'b1;
      end
   end

   assign send = can_send && grant_found;
   assign ret  = i_li_feedback;

   always_comb begin
      ptr_d   = ptr_q;
      data_d  = data_q;
      src_d   = src_q;
      valid_d = 1'b0;
      if (send) begin
         ptr_d   = (grant_idx == SRC_LAST) ? '0 : grant_idx + SRC_ONE;
         data_d  = words[grant_idx];
         src_d   = grant_idx;
         valid_d = 1'b1;
      end
   end

   // A return with the counter already full is a protocol error; the count saturates.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      case ({send, ret})
         2'b10: cnt_d = cnt_q - CNT_ONE;
         2'b01: begin
            if (cnt_q == CNT_FULL) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= CNT_FULL;
         ptr_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         src_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         src_q   <= src_d;
         err_q   <= err_d;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_src        = src_q;
   assign o_credit_err = err_q;

endmodule

// File: tb/tb_li_credit_arbiter.sv
// Directed bench for li_credit_arbiter: reset, round-robin, credit exhaustion/return,
// sparse wrap, credit overflow and mid-stream reset.
module tb_li_credit_arbiter;

   localparam int DW = 16;
   localparam int NR = 4;
   localparam int CR = 8;
   localparam int SW = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic [NR*DW-1:0]  i_data;
   logic [NR-1:0]     i_valid;
   logic [NR-1:0]     o_li_feedback;
   logic [DW-1:0]     o_data;
   logic              o_valid;
   logic [SW-1:0]     o_src;
   logic              i_li_feedback;
   logic              o_credit_err;

   int n_assert = 0;
   int n_fail   = 0;

   li_credit_arbiter #(
      .DATA_WIDTH (DW),
      .N_REQ      (NR),
      .CREDITS    (CR)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .i_data        (i_data),
      .i_valid       (i_valid),
      .o_li_feedback (o_li_feedback),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .o_src         (o_src),
      .i_li_feedback (i_li_feedback),
      .o_credit_err  (o_credit_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [SW-1:0] src, input logic [DW-1:0] data);
      chk({tag, "_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_src"},   32'(o_src),   32'(src));
      chk({tag, "_data"},  32'(o_data),  32'(data));
   endtask

   task automatic set_word(input int k, input logic [DW-1:0] w);
      i_data[k*DW +: DW] = w;
   endtask

   initial begin
      logic [SW-1:0] sp [3];
      logic [SW-1:0] es;

      // reset: feedback must stay low even with every requester valid
      reset         = 1'b1;
      i_valid       = 4'hF;
      i_li_feedback = 1'b1;
      i_data        = '0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("rst_fb", 32'(o_li_feedback), 32'd0);
         cycle();
      end
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_data",  32'(o_data),  32'd0);
      chk("rst_src",   32'(o_src),   32'd0);
      chk("rst_err",   32'(o_credit_err), 32'd0);

      // idle
      reset         = 1'b0;
      i_valid       = 4'h0;
      i_li_feedback = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("idle_fb", 32'(o_li_feedback), 32'd0);
         cycle();
         chk("idle_valid", 32'(o_valid), 32'd0);
         chk("idle_err",   32'(o_credit_err), 32'd0);
      end

      // round robin, all valid, credit returned each cycle
      i_valid       = 4'hF;
      i_li_feedback = 1'b1;
      for (int s = 0; s < 12; s++) begin
         for (int k = 0; k < NR; k++) set_word(k, DW'(k*16 + s));
         es = SW'(s % NR);
         #1;
         chk("rr_fb", 32'(o_li_feedback), 32'(1 << (s % NR)));
         cycle();
         expect_out("rr", es, DW'((s % NR)*16 + s));
      end
      chk("rr_err", 32'(o_credit_err), 32'd0);

      // credit exhaustion: requester 2 only, no returns
      i_li_feedback = 1'b0;
      i_valid       = 4'b0100;
      set_word(2, 16'h2ABC);
      for (int c = 0; c < CR; c++) begin
         #1;
         chk("ex_fb", 32'(o_li_feedback), 32'h4);
         cycle();
         expect_out("ex", 2'd2, 16'h2ABC);
      end
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("ex_dry_fb", 32'(o_li_feedback), 32'd0);
         cycle();
         chk("ex_dry_valid", 32'(o_valid), 32'd0);
      end
      // return one credit: no same-cycle bypass, one accept next cycle
      i_li_feedback = 1'b1;
      #1;
      chk("nobypass_fb", 32'(o_li_feedback), 32'd0);
      cycle();
      chk("nobypass_valid", 32'(o_valid), 32'd0);
      i_li_feedback = 1'b0;
      set_word(2, 16'h2DEF);
      #1;
      chk("ret_fb", 32'(o_li_feedback), 32'h4);
      cycle();
      expect_out("ret", 2'd2, 16'h2DEF);
      #1;
      chk("ret_dry_fb", 32'(o_li_feedback), 32'd0);
      cycle();
      chk("ret_dry_valid", 32'(o_valid), 32'd0);

      // refill to CREDITS (ptr is 3)
      i_valid       = 4'h0;
      i_li_feedback = 1'b1;
      for (int c = 0; c < CR; c++) begin
         #1;
         chk("refill_fb", 32'(o_li_feedback), 32'd0);
         cycle();
      end
      chk("refill_err", 32'(o_credit_err), 32'd0);

      // sparse 1 and 3 from ptr 3, send+return at full count
      i_valid = 4'b1010;
      set_word(1, 16'hB001);
      set_word(3, 16'hA003);
      sp[0] = 2'd3;
      sp[1] = 2'd1;
      sp[2] = 2'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sp_fb", 32'(o_li_feedback), 32'(1 << sp[i]));
         cycle();
         expect_out("sp", sp[i], (sp[i] == 2'd3) ? 16'hA003 : 16'hB001);
      end
      chk("sendret_full_err", 32'(o_credit_err), 32'd0);

      // overflow: return with counter full and no send
      i_valid       = 4'h0;
      i_li_feedback = 1'b1;
      #1;
      chk("ovf_fb", 32'(o_li_feedback), 32'd0);
      cycle();
      chk("ovf_err", 32'(o_credit_err), 32'd1);
      i_li_feedback = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("ovf_sticky", 32'(o_credit_err), 32'd1);
      end
      i_valid       = 4'b0001;
      i_li_feedback = 1'b1;
      set_word(0, 16'h0F0F);
      cycle();
      expect_out("ovf_send", 2'd0, 16'h0F0F);
      chk("ovf_sticky2", 32'(o_credit_err), 32'd1);

      // drain to cnt=3 with o_valid high
      i_li_feedback = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("pre_fb", 32'(o_li_feedback), 32'h1);
         cycle();
         expect_out("pre", 2'd0, 16'h0F0F);
      end

      // mid-stream reset, returns during reset ignored
      reset         = 1'b1;
      i_valid       = 4'hF;
      i_li_feedback = 1'b1;
      #1;
      chk("mr_fb", 32'(o_li_feedback), 32'd0);
      cycle();
      chk("mr_valid", 32'(o_valid), 32'd0);
      chk("mr_src",   32'(o_src),   32'd0);
      chk("mr_data",  32'(o_data),  32'd0);
      chk("mr_err",   32'(o_credit_err), 32'd0);
      reset         = 1'b0;
      i_li_feedback = 1'b0;
      for (int k = 0; k < NR; k++) set_word(k, DW'(16'h0040 + k));
      for (int i = 0; i < CR; i++) begin
         es = SW'(i % NR);
         #1;
         chk("post_fb", 32'(o_li_feedback), 32'(1 << (i % NR)));
         cycle();
         expect_out("post", es, DW'(16'h0040 + (i % NR)));
      end
      #1;
      chk("post_dry_fb", 32'(o_li_feedback), 32'd0);
      cycle();
      chk("post_dry_valid", 32'(o_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
